// File: rtl/comparatore_operand_loader_pkg.sv
// Shared types for the comparator operand loader: FSM state encoding and default sizes.
// Optional hit statistics are enabled with COMP_LOADER_STATS_EN.
package comparatore_operand_loader_pkg;

    localparam int DEFAULT_WIDTH = 3;
    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        LOAD_C = 3'd2,
        EVAL   = 3'd3,
        HOLD   = 3'd4
    } state_e;

    function automatic logic is_load_state(state_e s);
        return (s == LOAD_A) || (s == LOAD_B) || (s == LOAD_C);
    endfunction

endpackage

// File: rtl/comparatore_operand_loader_if.sv
// Bundle of operand stream, comparator link and result stream for the operand loader.
// With COMP_LOADER_STATS_EN defined the bundle also carries the saturating hit counter.
//
// Handshake: a word moves on an edge where valid and ready are both high; the sender
// keeps data stable while valid is high and ready is low, and ready never waits on valid.
interface comparatore_operand_loader_if
    import comparatore_operand_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
`ifdef COMP_LOADER_STATS_EN
    , parameter int CNT_W = DEFAULT_CNT_W
`endif
);
    logic             flush;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             cmp_out;
    logic             res_data;
    logic             res_valid;
    logic             res_ready;
    logic             busy;
    logic [2:0]       state_dbg;
`ifdef COMP_LOADER_STATS_EN
    logic [CNT_W-1:0] hit_cnt;

    modport master (
        input  flush, in_data, in_valid, cmp_out, res_ready,
        output in_ready, a, b, c, res_data, res_valid, busy, state_dbg, hit_cnt
    );
    modport slave (
        output flush, in_data, in_valid, cmp_out, res_ready,
        input  in_ready, a, b, c, res_data, res_valid, busy, state_dbg, hit_cnt
    );
`else
    modport master (
        input  flush, in_data, in_valid, cmp_out, res_ready,
        output in_ready, a, b, c, res_data, res_valid, busy, state_dbg
    );
    modport slave (
        output flush, in_data, in_valid, cmp_out, res_ready,
        input  in_ready, a, b, c, res_data, res_valid, busy, state_dbg
    );
`endif
endinterface

// File: rtl/comparatore_operand_loader.sv
// Serially loads operands a, b, c for comparatore_3bit, samples its output once and returns it
// on a result stream. COMP_LOADER_STATS_EN adds a saturating count of delivered 1-results.
module comparatore_operand_loader
    import comparatore_operand_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
`ifdef COMP_LOADER_STATS_EN
    , parameter int CNT_W = DEFAULT_CNT_W
`endif
) (
    input logic                          clk,
    input logic                          rst_n,
    comparatore_operand_loader_if.master lif
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             res_data_q, res_data_d;
    logic             res_valid_q, res_valid_d;
    logic             in_ready;
    logic             accept;

    assign in_ready = is_load_state(state_q);
    assign accept   = lif.in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;

        case (state_q)
            LOAD_A: if (accept) begin
                a_d     = lif.in_data;
                state_d = LOAD_B;
            end
            LOAD_B: if (accept) begin
                b_d     = lif.in_data;
                state_d = LOAD_C;
            end
            LOAD_C: if (accept) begin
                c_d     = lif.in_data;
                state_d = EVAL;
            end
            // a/b/c have been stable for a full cycle, so the comparator output is settled.
            EVAL: begin
                res_data_d  = lif.cmp_out;
                res_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: if (lif.res_ready) begin
                res_valid_d = 1'b0;
                state_d     = LOAD_A;
            end
            default: state_d = LOAD_A;
        endcase

        // Abort wins over any handshake on the same edge.
        if (lif.flush) begin
            state_d     = LOAD_A;
            res_valid_d = 1'b0;
            a_d         = '0;
            b_d         = '0;
            c_d         = '0;
        end
    end

`ifdef COMP_LOADER_STATS_EN
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

    // A result dropped by flush on its handshake edge was never delivered, so it is not counted.
    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (!lif.flush && res_valid_q && lif.res_ready && res_data_q && !(&hit_cnt_q))
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD_A;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            res_data_q  <= 1'b0;
            res_valid_q <= 1'b0;
`ifdef COMP_LOADER_STATS_EN
            hit_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
`ifdef COMP_LOADER_STATS_EN
            hit_cnt_q   <= hit_cnt_d;
`endif
        end
    end

    assign lif.in_ready  = in_ready;
    assign lif.a         = a_q;
    assign lif.b         = b_q;
    assign lif.c         = c_q;
    assign lif.res_data  = res_data_q;
    assign lif.res_valid = res_valid_q;
    assign lif.busy      = (state_q != LOAD_A);
    assign lif.state_dbg = state_q;
`ifdef COMP_LOADER_STATS_EN
    assign lif.hit_cnt   = hit_cnt_q;
`endif

endmodule

// File: tb/tb_comparatore_operand_loader.sv
// Directed bench for comparatore_operand_loader; a behavioural comparator (a < b < c) stands in
// for comparatore_3bit. Define COMP_LOADER_STATS_EN to also exercise the saturating hit counter.
module tb_comparatore_operand_loader;
    import comparatore_operand_loader_pkg::*;

    localparam int WIDTH = 3;
`ifdef COMP_LOADER_STATS_EN
    localparam int CNT_W = 2;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

`ifdef COMP_LOADER_STATS_EN
    comparatore_operand_loader_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) lif ();
    comparatore_operand_loader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .lif(lif));
`else
    comparatore_operand_loader_if #(.WIDTH(WIDTH)) lif ();
    comparatore_operand_loader #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .lif(lif));
`endif

    function automatic logic cmp_model(logic [2:0] x, logic [2:0] y, logic [2:0] z);
        return (x < y) && (y < z);
    endfunction

    assign lif.cmp_out = cmp_model(lif.a, lif.b, lif.c);

    int n_pass  = 0;
    int n_total = 0;
    logic exp_q[$];

    // Drive one word from a negedge; returns on the negedge after it was accepted.
    task automatic send_word(input logic [2:0] d);
        int n = 0;
        lif.in_valid = 1'b1;
        lif.in_data  = d;
        while (!lif.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!lif.in_ready) begin
            n_total++;
            $display("FAIL send_word_timeout: in_ready=%0b required 1", lif.in_ready);
        end
        @(negedge clk);
        lif.in_valid = 1'b0;
    endtask

    // Wait for a result, accept it after 'delay' cycles; returns on the negedge after handshake.
    task automatic get_result(input int delay, output logic ok, output logic d);
        int n = 0;
        while (!lif.res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = lif.res_valid;
        d  = lif.res_data;
        repeat (delay) @(negedge clk);
        lif.res_ready = 1'b1;
        @(negedge clk);
        lif.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_total++;
        if (lif.state_dbg !== 3'd0 || lif.a !== 3'd0 || lif.b !== 3'd0 || lif.c !== 3'd0)
            $display("FAIL reset_regs: state=%0d a=%0d b=%0d c=%0d required all 0",
                     lif.state_dbg, lif.a, lif.b, lif.c);
        else n_pass++;
        n_total++;
        if (lif.res_valid !== 1'b0 || lif.res_data !== 1'b0 || lif.in_ready !== 1'b1 || lif.busy !== 1'b0)
            $display("FAIL reset_flags: res_valid=%0b res_data=%0b in_ready=%0b busy=%0b required 0 0 1 0",
                     lif.res_valid, lif.res_data, lif.in_ready, lif.busy);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (lif.state_dbg !== 3'd0) $display("FAIL reset_idle_state: got %0d required 0", lif.state_dbg);
        else n_pass++;
    endtask

    task automatic test_stream();
        lif.in_valid  = 1'b1;
        lif.res_ready = 1'b1;
        lif.in_data   = 3'd0;
        @(negedge clk);
        lif.in_data = 3'd3;
        @(negedge clk);
        lif.in_data = 3'd5;
        @(negedge clk);
        n_total++;
        if (lif.a !== 3'd0 || lif.b !== 3'd3 || lif.c !== 3'd5)
            $display("FAIL stream_operands: a=%0d b=%0d c=%0d required 0 3 5", lif.a, lif.b, lif.c);
        else n_pass++;
        n_total++;
        if (lif.state_dbg !== 3'd3 || lif.in_ready !== 1'b0 || lif.res_valid !== 1'b0)
            $display("FAIL stream_eval: state=%0d in_ready=%0b res_valid=%0b required 3 0 0",
                     lif.state_dbg, lif.in_ready, lif.res_valid);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (lif.res_valid !== 1'b1 || lif.res_data !== 1'b1 || lif.in_ready !== 1'b0)
            $display("FAIL stream_result: res_valid=%0b res_data=%0b in_ready=%0b required 1 1 0",
                     lif.res_valid, lif.res_data, lif.in_ready);
        else n_pass++;
        lif.in_valid = 1'b0;
        @(negedge clk);
        lif.res_ready = 1'b0;
        n_total++;
        if (lif.res_valid !== 1'b0 || lif.in_ready !== 1'b1 || lif.state_dbg !== 3'd0)
            $display("FAIL stream_return: res_valid=%0b in_ready=%0b state=%0d required 0 1 0",
                     lif.res_valid, lif.in_ready, lif.state_dbg);
        else n_pass++;
        n_total++;
        if (lif.a !== 3'd0 || lif.b !== 3'd3 || lif.c !== 3'd5)
            $display("FAIL stream_operands_kept: a=%0d b=%0d c=%0d required 0 3 5", lif.a, lif.b, lif.c);
        else n_pass++;
    endtask

    task automatic test_hold();
        send_word(3'd3);
        send_word(3'd3);
        send_word(3'd4);
        lif.in_valid = 1'b1;
        lif.in_data  = 3'd7;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if (lif.res_valid !== 1'b1 || lif.res_data !== 1'b0 || lif.in_ready !== 1'b0 || lif.busy !== 1'b1)
                $display("FAIL hold_stable[%0d]: res_valid=%0b res_data=%0b in_ready=%0b busy=%0b required 1 0 0 1",
                         i, lif.res_valid, lif.res_data, lif.in_ready, lif.busy);
            else n_pass++;
            @(negedge clk);
        end
        lif.in_valid = 1'b0;
        n_total++;
        if (lif.a !== 3'd3 || lif.b !== 3'd3 || lif.c !== 3'd4)
            $display("FAIL hold_ignored_word: a=%0d b=%0d c=%0d required 3 3 4", lif.a, lif.b, lif.c);
        else n_pass++;
        lif.res_ready = 1'b1;
        @(negedge clk);
        lif.res_ready = 1'b0;
        n_total++;
        if (lif.state_dbg !== 3'd0 || lif.res_valid !== 1'b0 || lif.busy !== 1'b0)
            $display("FAIL hold_release: state=%0d res_valid=%0b busy=%0b required 0 0 0",
                     lif.state_dbg, lif.res_valid, lif.busy);
        else n_pass++;
    endtask

    task automatic test_flush();
        send_word(3'd1);
        send_word(3'd7);
        lif.flush    = 1'b1;
        lif.in_valid = 1'b1;
        lif.in_data  = 3'd5;
        @(negedge clk);
        lif.flush    = 1'b0;
        lif.in_valid = 1'b0;
        n_total++;
        if (lif.state_dbg !== 3'd0 || lif.a !== 3'd0 || lif.b !== 3'd0 || lif.c !== 3'd0)
            $display("FAIL flush_clear: state=%0d a=%0d b=%0d c=%0d required all 0",
                     lif.state_dbg, lif.a, lif.b, lif.c);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (lif.res_valid !== 1'b0) $display("FAIL flush_no_result[%0d]: res_valid=%0b required 0", i, lif.res_valid);
            else n_pass++;
            @(negedge clk);
        end
        send_word(3'd6);
        n_total++;
        if (lif.a !== 3'd6 || lif.state_dbg !== 3'd1)
            $display("FAIL flush_next_word: a=%0d state=%0d required 6 1", lif.a, lif.state_dbg);
        else n_pass++;
        lif.flush = 1'b1;
        @(negedge clk);
        lif.flush = 1'b0;
    endtask

    task automatic test_async_reset();
        send_word(3'd0);
        send_word(3'd3);
        send_word(3'd5);
        @(negedge clk);
        n_total++;
        if (lif.res_valid !== 1'b1) $display("FAIL areset_pre_hold: res_valid=%0b required 1", lif.res_valid);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (lif.res_valid !== 1'b0 || lif.res_data !== 1'b0 || lif.busy !== 1'b0 || lif.state_dbg !== 3'd0)
            $display("FAIL areset_flags: res_valid=%0b res_data=%0b busy=%0b state=%0d required 0 0 0 0",
                     lif.res_valid, lif.res_data, lif.busy, lif.state_dbg);
        else n_pass++;
        n_total++;
        if (lif.a !== 3'd0 || lif.b !== 3'd0 || lif.c !== 3'd0)
            $display("FAIL areset_regs: a=%0d b=%0d c=%0d required 0 0 0", lif.a, lif.b, lif.c);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_triples();
        logic [2:0] ta [11] = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd0, 3'd7, 3'd2, 3'd6, 3'd0, 3'd4, 3'd3};
        logic [2:0] tb_ [11] = '{3'd3, 3'd2, 3'd3, 3'd4, 3'd0, 3'd7, 3'd6, 3'd1, 3'd1, 3'd5, 3'd4};
        logic [2:0] tc [11] = '{3'd5, 3'd3, 3'd4, 3'd3, 3'd0, 3'd7, 3'd7, 3'd2, 3'd7, 3'd5, 3'd4};
        logic       te [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic ok, d, e;
        for (int i = 0; i < 11; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_word(ta[i]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_word(tb_[i]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_word(tc[i]);
            exp_q.push_back(te[i]);
            get_result($urandom_range(0, 2), ok, d);
            n_total++;
            if (ok !== 1'b1) $display("FAIL triple_timeout[%0d]: res_valid=%0b required 1", i, ok);
            else n_pass++;
            e = exp_q.pop_front();
            n_total++;
            if (d !== e) $display("FAIL triple_result[%0d]: res_data=%0b required %0b", i, d, e);
            else n_pass++;
            n_total++;
            if (lif.res_valid !== 1'b0 || lif.state_dbg !== 3'd0)
                $display("FAIL triple_no_dup[%0d]: res_valid=%0b state=%0d required 0 0", i, lif.res_valid, lif.state_dbg);
            else n_pass++;
        end
        n_total++;
        if (exp_q.size() !== 0) $display("FAIL triple_queue_left: %0d entries required 0", exp_q.size());
        else n_pass++;
    endtask

`ifdef COMP_LOADER_STATS_EN
    task automatic test_stats();
        logic [1:0] exp_hit [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic ok, d;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (lif.hit_cnt !== 2'd0) $display("FAIL stats_reset: hit_cnt=%0d required 0", lif.hit_cnt);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            send_word(3'd0);
            send_word(3'd3);
            send_word(3'd5);
            get_result(0, ok, d);
            n_total++;
            if (ok !== 1'b1 || d !== 1'b1 || lif.hit_cnt !== exp_hit[k])
                $display("FAIL stats_hit[%0d]: ok=%0b res_data=%0b hit_cnt=%0d required 1 1 %0d",
                         k, ok, d, lif.hit_cnt, exp_hit[k]);
            else n_pass++;
        end
    endtask
`endif

    initial begin
        rst_n         = 1'b0;
        lif.flush     = 1'b0;
        lif.in_valid  = 1'b0;
        lif.in_data   = 3'd0;
        lif.res_ready = 1'b0;
        test_reset();
        test_stream();
        test_hold();
        test_flush();
        test_async_reset();
        test_triples();
`ifdef COMP_LOADER_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
